gsim_residual_check: RTL

Downstream checker for the 16-unknown Gauss-Seidel solver. It snoops the 16 right-hand-side words the solver receives and captures the 16 Q16.16 solution words the solver emits. It then recomputes each row of the fixed banded system and reports the per-row residual, the maximum absolute residual, and a pass flag against a tolerance. It sits on the solver's output stream and is used by the bench and on-chip self-test to qualify convergence.

---
 rtl/gsim_residual_check.sv | 122 ++++++++++++
 1 files changed

// File: rtl/gsim_residual_check.sv
// Residual checker for the 16-unknown banded Gauss-Seidel solver: captures b and x,
// recomputes each row of A*x - b, and reports per-row residuals, max |r| and a pass flag.
module gsim_residual_check #(
    parameter logic [39:0] TOL = 40'd65536
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_b_valid,
    input  logic [15:0] i_b_in,
    input  logic        i_x_valid,
    input  logic [31:0] i_x_in,
    output logic        o_r_valid,
    output logic [39:0] o_r_out,
    output logic [3:0]  o_r_row,
    output logic        o_done,
    output logic [39:0] o_max_abs,
    output logic        o_pass
);

    typedef enum logic [1:0] {StLoadB, StLoadX, StEval, StFinish} state_t;

    state_t      r_state;
    logic [15:0] r_b_mem [16];
    logic [31:0] r_x_mem [16];
    logic [3:0]  r_b_cnt;
    logic [3:0]  r_x_cnt;
    logic [3:0]  r_row_i;
    logic [39:0] r_run_max;

    logic signed [39:0] w_xw [7];
    logic signed [39:0] w_s1, w_s2, w_s3, w_x0;
    logic signed [39:0] w_ax;
    logic signed [39:0] w_b_ext;
    logic signed [39:0] w_res;
    logic [39:0]        w_abs;

    // Neighbours x_{i-3}..x_{i+3}; indices outside 0..15 read as zero (negatives wrap high).
    always_comb begin
        for (int k = 0; k < 7; k++) begin
            logic [5:0] idx;
            idx = {2'b00, r_row_i} + 6'(k) - 6'd3;
            if (idx < 6'd16) begin
                w_xw[k] = {{8{r_x_mem[idx[3:0]][31]}}, r_x_mem[idx[3:0]]};
            end else begin
                w_xw[k] = '0;
            end
        end
    end

    always_comb begin
        w_x0    = w_xw[3];
        w_s1    = w_xw[2] + w_xw[4];
        w_s2    = w_xw[1] + w_xw[5];
        w_s3    = w_xw[0] + w_xw[6];
        w_ax    = (w_x0 <<< 4) + (w_x0 <<< 2)
                - ((w_s1 <<< 3) + (w_s1 <<< 2) + w_s1)
                + ((w_s2 <<< 2) + (w_s2 <<< 1))
                - w_s3;
        w_b_ext = {{24{r_b_mem[r_row_i][15]}}, r_b_mem[r_row_i]};
        w_res   = w_ax - (w_b_ext <<< 16);
        w_abs   = w_res[39] ? 40'(-w_res) : 40'(w_res);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= StLoadB;
            r_b_cnt   <= '0;
            r_x_cnt   <= '0;
            r_row_i   <= '0;
            r_run_max <= '0;
            for (int i = 0; i < 16; i++) begin
                r_b_mem[i] <= '0;
                r_x_mem[i] <= '0;
            end
            o_r_valid <= 1'b0;
            o_r_out   <= '0;
            o_r_row   <= '0;
            o_done    <= 1'b0;
            o_max_abs <= '0;
            o_pass    <= 1'b0;
        end else begin
            o_r_valid <= 1'b0;
            o_done    <= 1'b0;
            unique case (r_state)
                StLoadB: begin
                    if (i_b_valid) begin
                        r_b_mem[r_b_cnt] <= i_b_in;
                        r_b_cnt          <= r_b_cnt + 4'd1;
                        if (r_b_cnt == 4'd15) r_state <= StLoadX;
                    end
                end
                StLoadX: begin
                    if (i_x_valid) begin
                        r_x_mem[r_x_cnt] <= i_x_in;
                        r_x_cnt          <= r_x_cnt + 4'd1;
                        if (r_x_cnt == 4'd15) begin
                            r_state   <= StEval;
                            r_row_i   <= '0;
                            r_run_max <= '0;
                        end
                    end
                end
                StEval: begin
                    o_r_valid <= 1'b1;
                    o_r_out   <= w_res;
                    o_r_row   <= r_row_i;
                    if (w_abs > r_run_max) r_run_max <= w_abs;
                    r_row_i <= r_row_i + 4'd1;
                    if (r_row_i == 4'd15) r_state <= StFinish;
                end
                StFinish: begin
                    o_done    <= 1'b1;
                    o_max_abs <= r_run_max;
                    o_pass    <= (r_run_max <= TOL);
                    r_state   <= StLoadB;
                end
                default: r_state <= StLoadB;
            endcase
        end
    end

endmodule
